gate_tt_checker: RTL and testbench
==================================

# gate_tt_checker

Self-test sequencer for the two-input logic-gate unit. It drives `in1`/`in2` through all four input combinations and samples the unit's 24 gate outputs (8 gates × 3 modelling styles) after a settle interval. It compares them against an internally computed truth table and reports pass/fail with a per-output failure mask. It sits upstream of the gate unit, as the initiator of its input/output interface, and is started by a board-level button or controller.

## Interface

**Parameters**
- `SETTLE_CYCLES`, default 2: cycles between the SETTLE state being entered and sampling; legal range 1–15.
- `NUM_OUTS`, default 24: width of the observed output bus; fixed at 8 × 3 and must not be overridden.

**Ports**
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level-sampled; begins a run when high in IDLE.
- `drv_in1`, output, 1: registered drive to the gate unit's `in1`.
- `drv_in2`, output, 1: registered drive to the gate unit's `in2`.
- `dut_out`, input, 24: packed gate outputs; bit `8*s+g`.
  - `s`: 0 gate-level, 1 dataflow, 2 behavioural.
  - `g`: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT in1, 7 NOT in2.
- `busy`, output, 1: high from the start acceptance edge until DONE is entered.
- `done`, output, 1: one-cycle pulse at end of run.
- `pass`, output, 1: high when the last run had zero mismatches; valid from `done`, held until the next start.
- `fail_mask`, output, 24: sticky OR of mismatch bits over all vectors of the current run.
- `first_fail_vec`, output, 2: `{in1,in2}` of the first vector with any mismatch.
- `first_fail_valid`, output, 1: `first_fail_vec` is meaningful.

## Operation

**States:** IDLE, DRIVE, SETTLE, CHECK, DONE.

**IDLE**
- `start`=1 → DRIVE.
- On that edge:
  - vector index v:=0, `drv_in1`/`drv_in2`:=00
  - `fail_mask`:=0, `pass`:=0, `first_fail_valid`:=0, `busy`:=1

**DRIVE** (1 cycle)
- → SETTLE; settle counter := `SETTLE_CYCLES`−1.

**SETTLE**
- Counts down.
- At 0 → CHECK.

**CHECK** (1 cycle)
- Compare `dut_out` against `expected(v)`; `mism` = XOR of the two.
- On exit edge, `fail_mask` |= `mism`.
- If `mism`≠0 and `first_fail_valid`=0: latch `first_fail_vec`:=v and set `first_fail_valid`.
- If v<3: v:=v+1, drive new v, → DRIVE.
- If v=3: → DONE.

**DONE** (1 cycle)
- `done`=1, `busy`=0.
- `pass`:=(final `fail_mask`==0), including the last CHECK's mismatches.
- → IDLE.

**Vector order and expected values**
- Vector order is 00, 01, 10, 11, as `{in1,in2}`; v never wraps beyond 3.
- Expected values per vector are identical for all three styles (standard truth tables).

**Boundary cases**
- `start` held high across DONE: a new run starts on the first IDLE edge.
- `start` while busy: ignored.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. No partial results are retained.
- `dut_out` X/Z: counts as a mismatch.

## Timing

**Reset values:** every output is 0, and the state is IDLE.

**Latency**
- Per vector: `SETTLE_CYCLES`+2 cycles.
- `done` is high in cycle 4×(`SETTLE_CYCLES`+2) after the start acceptance edge: 16 cycles at default.

**Sampling**
- Drivers are stable for `SETTLE_CYCLES`+1 full cycles before the CHECK compare.
- `dut_out` is treated as combinational from `drv_in*`; no synchronisation is applied.

**Output validity**
- `pass`, `fail_mask` and `first_fail_*` are stable from the `done` cycle until the next start acceptance edge.

## Structure

**Shared header `gate_tt_pkg.vh`**
- Gate index constants `G_AND`..`G_NOT2`.
- Style constants `S_GATE`, `S_DATAFLOW`, `S_BEHAV`.
- `NUM_GATES`=8, `NUM_STYLES`=3.
- State encodings (3-bit).

**Sub-module `gate_tt_expected`**
- Combinational.
- Input: `{in1,in2}`; output: 24-bit expected vector, built by replicating the 8-bit golden pattern per style.
- Instantiated once in the top.

## Test plan

- **Ideal unit:** bench model of a fault-free gate unit; pulse `start`.
  - Required: `done` at cycle 16, `pass`=1, `fail_mask`=0, `first_fail_valid`=0.
  - Observe `drv_in*` sequence 00, 01, 10, 11.
- **Faulty behavioural NOR:** style-2 NOR driven as NAND.
  - Required: `pass`=0, `fail_mask`=24'h080000 (bit 19), `first_fail_vec`=01, `first_fail_valid`=1.
- **Stuck bit:** bit 0 stuck at 1.
  - Required: `fail_mask`=24'h000001, `first_fail_vec`=00.
- **Mid-run reset:** assert `rst_n`=0 at cycle 7 of a run.
  - Required: all outputs 0 immediately.
  - After release and a new `start`: a full clean run with `pass`=1.
- **Start while busy:** pulse `start` at cycle 5 of a run.
  - Required: no restart; `done` still at cycle 16.
  - With `start` held high continuously: back-to-back runs, `done` every 18 cycles (16 + DONE + IDLE).
- **SETTLE_CYCLES=1 build:**
  - Required: `done` at cycle 12.
  - Bench model with 1-cycle output delay still gives `pass`=1.

Source files
------------

// File: rtl/gate_tt_checker_pkg.sv
// Shared constants for the gate-unit self-test: output bit layout and FSM state encoding.
package gate_tt_checker_pkg;

    localparam int NUM_GATES  = 8;
    localparam int NUM_STYLES = 3;

    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NAND = 2;
    localparam int G_NOR  = 3;
    localparam int G_XOR  = 4;
    localparam int G_XNOR = 5;
    localparam int G_NOT1 = 6;
    localparam int G_NOT2 = 7;

    localparam int S_GATE     = 0;
    localparam int S_DATAFLOW = 1;
    localparam int S_BEHAV    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gate_tt_expected.sv
// Golden truth-table generator: one 8-gate pattern for {in1,in2}, replicated for every modelling style.
module gate_tt_expected
    import gate_tt_checker_pkg::*;
(
    input  logic [1:0]                      i_vec,
    output logic [NUM_GATES*NUM_STYLES-1:0] o_expected
);

    logic                 w_a;
    logic                 w_b;
    logic [NUM_GATES-1:0] w_gold;

    assign w_a = i_vec[1];
    assign w_b = i_vec[0];

    always_comb begin
        w_gold         = '0;
        w_gold[G_AND]  = w_a & w_b;
        w_gold[G_OR]   = w_a | w_b;
        w_gold[G_NAND] = ~(w_a & w_b);
        w_gold[G_NOR]  = ~(w_a | w_b);
        w_gold[G_XOR]  = w_a ^ w_b;
        w_gold[G_XNOR] = ~(w_a ^ w_b);
        w_gold[G_NOT1] = ~w_a;
        w_gold[G_NOT2] = ~w_b;
    end

    assign o_expected[S_GATE*NUM_GATES     +: NUM_GATES] = w_gold;
    assign o_expected[S_DATAFLOW*NUM_GATES +: NUM_GATES] = w_gold;
    assign o_expected[S_BEHAV*NUM_GATES    +: NUM_GATES] = w_gold;

endmodule

// File: rtl/gate_tt_checker.sv
// Self-test sequencer: walks {in1,in2} through 00..11, samples the gate unit after a settle
// interval and accumulates a sticky per-output mismatch mask plus the first failing vector.
module gate_tt_checker
    import gate_tt_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_OUTS      = NUM_GATES * NUM_STYLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                drv_in1,
    output logic                drv_in2,
    input  logic [NUM_OUTS-1:0] dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NUM_OUTS-1:0] fail_mask,
    output logic [1:0]          first_fail_vec,
    output logic                first_fail_valid
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_v;
    logic [3:0]          r_cnt;
    logic [NUM_OUTS-1:0] r_fail_mask;
    logic                r_pass;
    logic [1:0]          r_ffv;
    logic                r_ffval;
    logic [NUM_OUTS-1:0] w_exp;
    logic [NUM_OUTS-1:0] w_mism;
    logic                w_busy;
    logic                w_done;

    gate_tt_expected u_exp (
        .i_vec      (r_v),
        .o_expected (w_exp)
    );

    // Case inequality so an X/Z on the observed bus is flagged rather than masked.
    always_comb begin
        w_mism = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            w_mism[i] = (dut_out[i] !== w_exp[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_DRIVE;
            ST_DRIVE:  begin w_busy = 1'b1; w_next = ST_SETTLE; end
            ST_SETTLE: begin
                w_busy = 1'b1;
                if (r_cnt == 4'd0) w_next = ST_CHECK;
            end
            ST_CHECK:  begin
                w_busy = 1'b1;
                w_next = (r_v == 2'd3) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE:   begin w_done = 1'b1; w_next = ST_IDLE; end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v         <= 2'd0;
            r_cnt       <= 4'd0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_ffv       <= 2'd0;
            r_ffval     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_v         <= 2'd0;
                    r_fail_mask <= '0;
                    r_pass      <= 1'b0;
                    r_ffval     <= 1'b0;
                end
                ST_DRIVE:  r_cnt <= SETTLE_LD;
                ST_SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                ST_CHECK: begin
                    r_fail_mask <= r_fail_mask | w_mism;
                    if ((|w_mism) && !r_ffval) begin
                        r_ffv   <= r_v;
                        r_ffval <= 1'b1;
                    end
                    // Verdict includes this final vector, so it is ready in the DONE cycle.
                    if (r_v != 2'd3) r_v    <= r_v + 2'd1;
                    else             r_pass <= ~|(r_fail_mask | w_mism);
                end
                default: ;
            endcase
        end
    end

    assign drv_in1          = r_v[1];
    assign drv_in2          = r_v[0];
    assign busy             = w_busy;
    assign done             = w_done;
    assign pass             = r_pass;
    assign fail_mask        = r_fail_mask;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffval;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: a default build and a SETTLE_CYCLES=1 build, each driving a modelled gate unit.
module tb_gate_tt_checker;

    typedef struct packed {
        int          k;      // edges since start acceptance, -1 when idle
        logic [23:0] mask;
        logic        pass;
        logic [1:0]  ffv;
        logic        ffval;
        logic [1:0]  drv;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        d0_in1, d0_in2, d1_in1, d1_in2;
    logic [23:0] dut_out0, dut_out1, d1_q;
    logic        busy0, done0, pass0, ffval0, busy1, done1, pass1, ffval1;
    logic [23:0] mask0, mask1;
    logic [1:0]  ffv0, ffv1;
    int          flt0 = 0;
    int          n_cmp = 0, n_bad = 0;
    mst_t        ms0, ms1;

    always #5 clk = ~clk;

    gate_tt_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .drv_in1(d0_in1), .drv_in2(d0_in2),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0),
        .first_fail_vec(ffv0), .first_fail_valid(ffval0)
    );

    gate_tt_checker #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .drv_in1(d1_in1), .drv_in2(d1_in2),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
        .first_fail_vec(ffv1), .first_fail_valid(ffval1)
    );

    // Standard two-input truth table, bit g of each 8-bit style slice.
    function automatic logic [23:0] golden(input logic [1:0] v);
        logic a, b;
        logic [7:0] g;
        a = v[1];
        b = v[0];
        g = {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
        return {3{g}};
    endfunction

    // Gate unit as seen from outside: 0 fault-free, 1 behavioural NOR wired as NAND, 2 bit 0 stuck high.
    function automatic logic [23:0] plant(input logic [1:0] v, input int flt);
        logic [23:0] r;
        r = golden(v);
        if (flt == 1) r[19] = ~(v[1] & v[0]);
        if (flt == 2) r[0] = 1'b1;
        return r;
    endfunction

    assign dut_out0 = plant({d0_in1, d0_in2}, flt0);
    always @(posedge clk) d1_q <= plant({d1_in1, d1_in2}, 0);
    assign dut_out1 = d1_q;

    function automatic mst_t mst_rst();
        mst_t s;
        s = '0;
        s.k = -1;
        return s;
    endfunction

    // A run is 4 vectors of p edges each; vector v is judged on edge (v+1)*p, DONE lasts one edge.
    function automatic mst_t step(input mst_t s, input int p, input logic st, input int flt);
        mst_t n;
        logic [23:0] m;
        int v;
        n = s;
        if (s.k < 0) begin
            if (st) begin
                n.k = 0; n.mask = '0; n.pass = 1'b0; n.ffval = 1'b0; n.drv = 2'd0;
            end
        end else if (s.k >= 4 * p) begin
            n.k = -1;
        end else begin
            n.k = s.k + 1;
            if (n.k % p == 0) begin
                v = n.k / p - 1;
                m = plant(2'(v), flt) ^ golden(2'(v));
                n.mask = n.mask | m;
                if (m != 0 && !s.ffval) begin
                    n.ffv = 2'(v);
                    n.ffval = 1'b1;
                end
                if (v == 3) n.pass = (n.mask == 0);
                else        n.drv = 2'(v + 1);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms0 <= mst_rst();
            ms1 <= mst_rst();
        end else begin
            ms0 <= step(ms0, 4, start0, flt0);
            ms1 <= step(ms1, 3, start1, 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input string t, input mst_t m, input int p, input logic busy, input logic done,
                            input logic [1:0] drv, input logic pass, input logic [23:0] mask,
                            input logic [1:0] ffv, input logic ffval);
        chk({t, ".busy"}, 32'(busy), 32'(m.k >= 0 && m.k < 4 * p));
        chk({t, ".done"}, 32'(done), 32'(m.k == 4 * p));
        chk({t, ".drv"}, 32'(drv), 32'(m.drv));
        chk({t, ".pass"}, 32'(pass), 32'(m.pass));
        chk({t, ".mask"}, 32'(mask), 32'(m.mask));
        chk({t, ".ffval"}, 32'(ffval), 32'(m.ffval));
        chk({t, ".ffv"}, 32'(ffv), 32'(m.ffv));
    endtask

    // Every clock: advance one edge, then check both builds against the model on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst_n) begin
            cmp_inst("u0", ms0, 4, busy0, done0, {d0_in1, d0_in2}, pass0, mask0, ffv0, ffval0);
            cmp_inst("u1", ms1, 3, busy1, done1, {d1_in1, d1_in2}, pass1, mask1, ffv1, ffval1);
        end
    endtask

    task automatic run0(input int flt, input int poke, input int rst_at, output int cyc, output logic [7:0] seq);
        logic [1:0] last;
        flt0 = flt;
        start0 = 1'b1;
        tick();
        cyc = 0;
        last = {d0_in1, d0_in2};
        seq = {6'd0, last};
        while (cyc < 100 && !done0) begin
            start0 = (cyc + 1 == poke);
            tick();
            cyc++;
            if (busy0 && {d0_in1, d0_in2} != last) begin
                last = {d0_in1, d0_in2};
                seq = {seq[5:0], last};
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("midrst.outs", {busy0, done0, pass0, ffval0, d0_in1, d0_in2, ffv0, mask0}, 32'd0);
                #2 rst_n = 1'b1;
                return;
            end
        end
        start0 = 1'b0;
        chk("u0.done_seen", 32'(done0), 32'd1);
    endtask

    task automatic wait_done1(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done1 && cyc < 100);
        chk("u1.done_seen", 32'(done1), 32'd1);
    endtask

    initial begin
        int cyc;
        logic [7:0] seq;

        repeat (2) @(negedge clk);
        chk("rst.u0", {busy0, done0, pass0, ffval0, d0_in1, d0_in2, ffv0, mask0}, 32'd0);
        chk("rst.u1", {busy1, done1, pass1, ffval1, d1_in1, d1_in2, ffv1, mask1}, 32'd0);
        rst_n = 1'b1;
        tick();

        chk("gold.00", 32'(golden(2'b00)), 32'h00ECECEC);
        chk("gold.01", 32'(golden(2'b01)), 32'h00565656);
        chk("gold.10", 32'(golden(2'b10)), 32'h00969696);
        chk("gold.11", 32'(golden(2'b11)), 32'h00232323);

        run0(0, -1, -1, cyc, seq);
        chk("ideal.latency", 32'(cyc), 32'd16);
        chk("ideal.pass", 32'(pass0), 32'd1);
        chk("ideal.mask", 32'(mask0), 32'd0);
        chk("ideal.ffval", 32'(ffval0), 32'd0);
        chk("ideal.drvseq", 32'(seq), 32'h1B);
        repeat (2) tick();

        run0(1, -1, -1, cyc, seq);
        chk("nor.pass", 32'(pass0), 32'd0);
        chk("nor.mask", 32'(mask0), 32'h080000);
        chk("nor.ffv", 32'(ffv0), 32'd1);
        chk("nor.ffval", 32'(ffval0), 32'd1);
        repeat (2) tick();
        chk("nor.hold_mask", 32'(mask0), 32'h080000);

        run0(2, -1, -1, cyc, seq);
        chk("stuck.pass", 32'(pass0), 32'd0);
        chk("stuck.mask", 32'(mask0), 32'h000001);
        chk("stuck.ffv", 32'(ffv0), 32'd0);
        chk("stuck.ffval", 32'(ffval0), 32'd1);
        repeat (2) tick();

        run0(0, -1, 7, cyc, seq);
        repeat (2) tick();
        run0(0, -1, -1, cyc, seq);
        chk("postrst.latency", 32'(cyc), 32'd16);
        chk("postrst.pass", 32'(pass0), 32'd1);
        repeat (2) tick();

        run0(0, 5, -1, cyc, seq);
        chk("busystart.latency", 32'(cyc), 32'd16);
        repeat (2) tick();

        start0 = 1'b1;
        tick();
        cyc = 0;
        do begin tick(); cyc++; end while (!done0 && cyc < 100);
        chk("b2b.first", 32'(cyc), 32'd16);
        cyc = 0;
        do begin tick(); cyc++; end while (!done0 && cyc < 100);
        chk("b2b.period", 32'(cyc), 32'd18);
        chk("b2b.pass", 32'(pass0), 32'd1);
        start0 = 1'b0;
        repeat (3) tick();
        chk("b2b.stopped", 32'(busy0), 32'd0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(cyc);
        chk("s1.latency", 32'(cyc), 32'd12);
        chk("s1.pass", 32'(pass1), 32'd1);
        chk("s1.mask", 32'(mask1), 32'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
